// File: rtl/amo_pkg.sv
// Shared AMO definitions: FSM state encoding, one-hot ALU opcodes, request payload
// and the opcode legality check used by decode, the ALU and the sequencer.
package amo_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 16;
  localparam int unsigned ALUW = 64;
  localparam int unsigned RDW  = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    EXEC,
    WR_REQ,
    RESP
  } amo_state_t;

  localparam logic [OPW-1:0] OP_ADD  = 16'd1;
  localparam logic [OPW-1:0] OP_XOR  = 16'd4;
  localparam logic [OPW-1:0] OP_OR   = 16'd8;
  localparam logic [OPW-1:0] OP_AND  = 16'd16;
  localparam logic [OPW-1:0] OP_SWAP = 16'd8192;
  localparam logic [OPW-1:0] OP_MAX  = 16'd16384;
  localparam logic [OPW-1:0] OP_MIN  = 16'd32768;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rs2;
    logic [RDW-1:0]  rd;
  } amo_req_t;

  // Zero and multi-hot encodings fall through to illegal.
  function automatic logic is_legal_amo(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SWAP, OP_MAX, OP_MIN: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/amo_sequencer_if.sv
// Bundle of request, memory-port, ALU and response signals around the AMO sequencer.
// master = the sequencer, slave = its surroundings (issue, memory, ALU, writeback).
interface amo_sequencer_if;
  import amo_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [OPW-1:0]      req_op;
  logic [XLEN-1:0]     req_addr;
  logic [XLEN-1:0]     req_rs2;
  logic [RDW-1:0]      req_rd;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_we;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_rvalid;
  logic [XLEN-1:0]     mem_rdata;

  logic [XLEN-1:0]     alu_v1;
  logic [XLEN-1:0]     alu_v2;
  logic [OPW-1:0]      alu_instructions;
  logic [ALUW-1:0]     alu_result;

  logic                rsp_valid;
  logic [RDW-1:0]      rsp_rd;
  logic [XLEN-1:0]     rsp_data;
  logic                rsp_err;

  modport master (
    input  req_valid, req_op, req_addr, req_rs2, req_rd,
    output req_ready,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    output alu_v1, alu_v2, alu_instructions,
    input  alu_result,
    output rsp_valid, rsp_rd, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_addr, req_rs2, req_rd,
    input  req_ready,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata,
    input  alu_v1, alu_v2, alu_instructions,
    output alu_result,
    input  rsp_valid, rsp_rd, rsp_data, rsp_err
  );

endinterface

// File: rtl/amo_timeout_ctr.sv
// Saturating memory-wait watchdog; only exists when AMO_TIMEOUT_EN is defined.
// expired_c rises on the LIMIT-th counted cycle since the last clear.
`ifdef AMO_TIMEOUT_EN
module amo_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired_c = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/amo_sequencer.sv
// RV32A AMO read-modify-write sequencer: read word, run (old, rs2) through the ALU,
// write the result back and return old for rd. Memory-wait watchdog under AMO_TIMEOUT_EN.
module amo_sequencer
  import amo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  amo_sequencer_if.master io
);

  amo_state_t      state;
  amo_req_t        req_q;
  logic [XLEN-1:0] old_q;
  logic            tmo_expired;
  logic            unused_alu_hi;

  // Only the low word of the ALU result is architecturally meaningful.
  assign unused_alu_hi = ^io.alu_result[ALUW-1:XLEN];

`ifdef AMO_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  // Restart the count on entry to RD_REQ (from IDLE) and to RD_WAIT (read accepted).
  assign tmo_clr = (state == IDLE) || ((state == RD_REQ) && io.mem_req_ready);
  assign tmo_en  = (state == RD_REQ) || (state == RD_WAIT);

  amo_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tmo_clr),
    .en        (tmo_en),
    .expired_c (tmo_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo_expired    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      req_q               <= '0;
      old_q               <= '0;
      io.req_ready        <= 1'b1;
      io.mem_req_valid    <= 1'b0;
      io.mem_we           <= 1'b0;
      io.mem_addr         <= '0;
      io.mem_wdata        <= '0;
      io.alu_v1           <= '0;
      io.alu_v2           <= '0;
      io.alu_instructions <= '0;
      io.rsp_valid        <= 1'b0;
      io.rsp_rd           <= '0;
      io.rsp_data         <= '0;
      io.rsp_err          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.req_valid) begin
            req_q        <= '{op: io.req_op, addr: io.req_addr, rs2: io.req_rs2, rd: io.req_rd};
            io.req_ready <= 1'b0;
            if (is_legal_amo(io.req_op)) begin
              state            <= RD_REQ;
              io.mem_req_valid <= 1'b1;
              io.mem_we        <= 1'b0;
              io.mem_addr      <= io.req_addr;
            end else begin
              state        <= RESP;
              io.rsp_valid <= 1'b1;
              io.rsp_rd    <= io.req_rd;
              io.rsp_data  <= '0;
              io.rsp_err   <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (io.mem_req_ready) begin
            state            <= RD_WAIT;
            io.mem_req_valid <= 1'b0;
            io.mem_addr      <= '0;
          end else if (tmo_expired) begin
            state            <= RESP;
            io.mem_req_valid <= 1'b0;
            io.mem_addr      <= '0;
            io.rsp_valid     <= 1'b1;
            io.rsp_rd        <= req_q.rd;
            io.rsp_data      <= '0;
            io.rsp_err       <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (io.mem_rvalid) begin
            state               <= EXEC;
            old_q               <= io.mem_rdata;
            io.alu_v1           <= io.mem_rdata;
            io.alu_v2           <= req_q.rs2;
            io.alu_instructions <= req_q.op;
          end else if (tmo_expired) begin
            state        <= RESP;
            io.rsp_valid <= 1'b1;
            io.rsp_rd    <= req_q.rd;
            io.rsp_data  <= '0;
            io.rsp_err   <= 1'b1;
          end
        end
        EXEC: begin
          // ALU operands are live for this single cycle; capture the truncated result.
          state               <= WR_REQ;
          io.alu_v1           <= '0;
          io.alu_v2           <= '0;
          io.alu_instructions <= '0;
          io.mem_req_valid    <= 1'b1;
          io.mem_we           <= 1'b1;
          io.mem_addr         <= req_q.addr;
          io.mem_wdata        <= io.alu_result[XLEN-1:0];
        end
        WR_REQ: begin
          if (io.mem_req_ready) begin
            state            <= RESP;
            io.mem_req_valid <= 1'b0;
            io.mem_we        <= 1'b0;
            io.mem_addr      <= '0;
            io.mem_wdata     <= '0;
            io.rsp_valid     <= 1'b1;
            io.rsp_rd        <= req_q.rd;
            io.rsp_data      <= old_q;
            io.rsp_err       <= 1'b0;
          end
        end
        RESP: begin
          state        <= IDLE;
          io.rsp_valid <= 1'b0;
          io.req_ready <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          io.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Multi-cycle read-modify-write sequencer for RV32A AMO instructions.
- Sits between decode/issue and the data-memory port, and drives the 32-bit combinational ALU's operand and one-hot opcode inputs.
- Per request: reads the memory word, sends (old, rs2) through the ALU, writes back the result, and returns the old value for rd.

Parameters:
- XLEN, 32, operand/address/data width.
- OPW, 16, width of the one-hot ALU opcode.
- TIMEOUT_CYCLES, 255, memory-wait watchdog limit; used only with AMO_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  AMO request valid.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  OPW  one-hot ALU opcode for the AMO.
- req_addr  in  XLEN  word address.
- req_rs2  in  XLEN  rs2 operand.
- req_rd  in  5  destination register.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  write data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- alu_v1  out  XLEN  ALU operand 1 (old memory value).
- alu_v2  out  XLEN  ALU operand 2 (rs2).
- alu_instructions  out  OPW  ALU one-hot opcode.
- alu_result  in  64  ALU output; only [31:0] is used.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rd  out  5  destination register.
- rsp_data  out  XLEN  old memory value.
- rsp_err  out  1  illegal opcode or timeout.

Behaviour:
- Reset values: all outputs 0, except req_ready=1. State IDLE. All internal registers cleared.
- Reset asserted mid-operation aborts immediately. No memory write is issued after reset release.
- Legal opcodes: 1 (ADD), 4 (XOR), 8 (OR), 16 (AND), 8192 (SWAP), 16384 (MAX), 32768 (MIN).
- MAX/MIN compare unsigned, per ALU semantics.
- Any other value, including zero or multi-hot, is illegal.
- FSM states: IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/addr/rs2/rd.
  - Legal op -> RD_REQ. Illegal op -> RESP with rsp_err=1, rsp_data=0, and no memory access.
- RD_REQ: mem_req_valid=1, mem_we=0, mem_addr=addr. Hold until mem_req_ready, then -> RD_WAIT.
- RD_WAIT: on mem_rvalid, latch mem_rdata as old -> EXEC.
  - mem_rvalid in the same cycle as the RD_REQ handshake is ignored. Read data arrives at least one cycle after acceptance.
- EXEC (exactly 1 cycle):
  - alu_v1=old, alu_v2=rs2, alu_instructions=op.
  - Register alu_result[31:0] as new -> WR_REQ.
  - ALU inputs are 0 in every other state, so the ALU output reads 0.
- WR_REQ: mem_req_valid=1, mem_we=1, mem_addr=addr, mem_wdata=new. Hold until mem_req_ready -> RESP.
- RESP: rsp_valid=1 for one cycle, rsp_rd=rd, rsp_data=old -> IDLE.
- rsp_data/rsp_rd/rsp_err are held until the next response. rsp_valid is 0 otherwise.
- req_ready=0 in every state except IDLE. Exactly one request is outstanding.
- Latency with zero-wait memory (acceptance to rsp_valid): 5 cycles (RD_REQ, RD_WAIT, EXEC, WR_REQ, RESP).
- Memory request signals stay stable while mem_req_valid=1 and mem_req_ready=0.
- ADD wraps modulo 2^32 via truncation of alu_result.

Optional Feature:
- Macro AMO_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_REQ and RD_WAIT and clears on state entry.
  - Reaching TIMEOUT_CYCLES without the handshake or data -> RESP with rsp_err=1, rsp_data=0, and no write.
- Undefined: no counter; the sequencer waits indefinitely.

Decomposition:
- Shared package amo_pkg holds:
  - state enum;
  - ALU one-hot opcode constants (OP_ADD=16'd1 ... OP_MIN=16'd32768), shared with decode and the ALU;
  - function is_legal_amo(op).
- One sub-module, amo_timeout_ctr: a saturating counter with clear and an expired flag, instantiated only under AMO_TIMEOUT_EN.

Test Plan:
- AMOADD, mem[0x100]=5, rs2=7, rd=3, zero-wait memory -> read addr 0x100, write 12; rsp_valid with rd=3, data=5, err=0, 5 cycles after accept.
- AMOMAX, mem=0x10, rs2=0x20 -> write 0x20, rsp_data 0x10. AMOMIN with the same values -> write 0x10.
- AMOSWAP, mem=0xDEADBEEF, rs2=0x1 -> write 0x1, rsp_data 0xDEADBEEF. AMOADD 0xFFFFFFFF+2 -> write 0x1.
- req_op=16'd2 (SUB, illegal) -> no mem_req_valid, rsp_err=1, rsp_data=0; req_ready back to 1 next cycle.
- mem_req_ready low for 3 cycles in both RD_REQ and WR_REQ -> addr/wdata stable throughout; req_ready=0 until after RESP.
- rst_n pulled low during RD_WAIT -> all outputs 0 immediately, no write issued. With AMO_TIMEOUT_EN, withhold mem_rvalid for 255 cycles -> rsp_err=1.
